// File: rtl/score_display_pkg.sv
// Shared constants, state encoding and helpers for the score display:
// segment codes, the maximum score and one serial double-dabble step.
package score_display_pkg;

  localparam logic [13:0] MAX_SCORE  = 14'd9999;
  localparam logic [15:0] BCD_MAX    = 16'h9999;
  localparam logic [3:0]  SHIFT_LAST = 4'd13;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Add 3 to every nibble >= 5, then shift in the next binary bit.
  function automatic logic [15:0] dd_step(input logic [15:0] acc, input logic bit_in);
    logic [15:0] adj;
    adj = acc;
    for (int unsigned i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    return {adj[14:0], bit_in};
  endfunction

endpackage

// File: rtl/score_display_bcd_to_7seg.sv
// One BCD digit to active-low gfedcba segments; blank flag or a
// non-decimal nibble turns every segment off.
module bcd_to_7seg
  import score_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = i_blank ? SEG_BLANK : seg_code(i_digit);
  end

endmodule

// File: rtl/score_display.sv
// Reaction-timer score display: serial binary-to-BCD conversion of each
// captured result, best-score tracking and four leading-zero-blanked digits.
module score_display
  import score_display_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [13:0] iVALUE,
  input  logic        iLOAD,
  input  logic        iSEL_BEST,
  input  logic        iCLR_BEST,
  output logic [6:0]  oHEX0,
  output logic [6:0]  oHEX1,
  output logic [6:0]  oHEX2,
  output logic [6:0]  oHEX3,
  output logic        oBUSY,
  output logic [13:0] oBEST,
  output logic        oNEW_BEST
);

  state_t      r_state;
  logic [13:0] r_shift;
  logic [13:0] r_value;
  logic [15:0] r_acc;
  logic [3:0]  r_cnt;
  logic [15:0] r_last_bcd;
  logic [15:0] r_best_bcd;
  logic [13:0] r_best;
  logic        r_busy;
  logic        r_new_best;

  logic [13:0] w_clamped;
  logic [13:0] w_cmp_best;
  logic [15:0] w_src;
  logic [3:0]  w_blank;

  always_comb begin
    w_clamped  = (iVALUE > MAX_SCORE) ? MAX_SCORE : iVALUE;
    w_cmp_best = iCLR_BEST ? MAX_SCORE : r_best;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_value    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_last_bcd <= '0;
      r_best_bcd <= BCD_MAX;
      r_best     <= MAX_SCORE;
      r_busy     <= 1'b0;
      r_new_best <= 1'b0;
    end else begin
      r_new_best <= 1'b0;
      if (iCLR_BEST) begin
        r_best     <= MAX_SCORE;
        r_best_bcd <= BCD_MAX;
      end
      case (r_state)
        // oBUSY is registered and drops one edge after COMMIT; loads wait for it.
        ST_IDLE: begin
          if (iLOAD && !r_busy) begin
            r_shift <= w_clamped;
            r_value <= w_clamped;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_acc   <= dd_step(r_acc, r_shift[13]);
          r_shift <= {r_shift[12:0], 1'b0};
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == SHIFT_LAST) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_last_bcd <= r_acc;
          // Compare against 9999 when a clear lands on this cycle; later NBAs win.
          if (r_value < w_cmp_best) begin
            r_best     <= r_value;
            r_best_bcd <= r_acc;
            r_new_best <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_src      = iSEL_BEST ? r_best_bcd : r_last_bcd;
    w_blank    = '0;
    w_blank[3] = (w_src[15:12] == 4'd0);
    w_blank[2] = w_blank[3] && (w_src[11:8] == 4'd0);
    w_blank[1] = w_blank[2] && (w_src[7:4] == 4'd0);
  end

  bcd_to_7seg u_dig0 (.i_digit(w_src[3:0]),   .i_blank(w_blank[0]), .o_seg(oHEX0));
  bcd_to_7seg u_dig1 (.i_digit(w_src[7:4]),   .i_blank(w_blank[1]), .o_seg(oHEX1));
  bcd_to_7seg u_dig2 (.i_digit(w_src[11:8]),  .i_blank(w_blank[2]), .o_seg(oHEX2));
  bcd_to_7seg u_dig3 (.i_digit(w_src[15:12]), .i_blank(w_blank[3]), .o_seg(oHEX3));

  assign oBUSY     = r_busy;
  assign oBEST     = r_best;
  assign oNEW_BEST = r_new_best;

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter: none; all widths are fixed.
REQ-002 iCLK  in  1  sole clock; all logic on rising edge.
REQ-003 iRST_N  in  1  reset, synchronous, active-low.
REQ-004 iVALUE  in  14  binary result in ms from the reaction timer; valid range 0..9999.
REQ-005 iLOAD  in  1  single-cycle strobe to capture iVALUE.
REQ-006 iSEL_BEST  in  1  0 = display the last result; 1 = display the best result.
REQ-007 iCLR_BEST  in  1  single-cycle strobe that resets the best score to 9999.
REQ-008 oHEX0..oHEX3  out  7 each  active-low segments, bit order gfedcba; oHEX0 is the units digit.
REQ-009 oBUSY  out  1  high while a conversion is in progress.
REQ-010 oBEST  out  14  best (minimum) binary score.
REQ-011 oNEW_BEST  out  1  one-cycle pulse when a capture sets a new best.

Function
REQ-012 The FSM shall have three states: IDLE, SHIFT and COMMIT.
REQ-013 In IDLE, iLOAD=1 shall capture min(iVALUE, 9999) into the shift register, clear the BCD accumulator and the 4-bit iteration count, and enter SHIFT.
REQ-014 SHIFT shall run exactly 14 cycles of serial double-dabble: add 3 to each BCD nibble >=5, then shift left one bit from the binary register.
REQ-015 After the 14th SHIFT cycle, the FSM shall enter COMMIT for one cycle, then return to IDLE.
REQ-016 oBUSY shall be 1 in SHIFT and COMMIT and 0 in IDLE.
REQ-017 Latency: if iLOAD is sampled at edge N, the outputs shall update at edge N+15 and oBUSY shall fall at edge N+16.
REQ-018 In COMMIT, the last-result BCD register shall load the accumulator.
REQ-019 In COMMIT, if the captured value < oBEST (strictly), oBEST and the best BCD register shall load it and oNEW_BEST shall pulse for that cycle.
REQ-020 iLOAD shall be ignored while oBUSY=1; there is no queueing.
REQ-021 iCLR_BEST shall set oBEST to 9999 and the best BCD register to 9,9,9,9 in any state.
REQ-022 If iCLR_BEST coincides with COMMIT, the clear shall apply first and the comparison shall then use 9999.
REQ-023 Display source shall be selected combinationally by iSEL_BEST from registered BCD; a change takes effect in the same cycle.
REQ-024 Leading-zero blanking: each zero digit to the left of the most significant nonzero digit shall be blank (7'h7F); oHEX0 shall never be blank.
REQ-025 Segment codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 (hex); a nibble >9 shall display blank.

Reset
REQ-026 When iRST_N=0 at an edge, the block shall reset as follows: FSM=IDLE; oBUSY=0; oNEW_BEST=0; shift, accumulator and count registers=0; last BCD=0,0,0,0; oBEST=9999; best BCD=9,9,9,9.
REQ-027 After reset, with iSEL_BEST=0, the display shall show blank, blank, blank, "0".
REQ-028 Reset asserted mid-conversion shall abort it with no output update and no oNEW_BEST pulse.

Structure
REQ-029 A shared package shall hold the segment code constants, the blank code, the MAX_SCORE constant (9999) and the state encoding.
REQ-030 The sub-module bcd_to_7seg (combinational: nibble plus blank flag in, 7 segments out) shall be instantiated four times; all other logic shall stay in score_display.

Verification
REQ-031 Load 357 -> at N+15 HEX3..0 = 7F,30,12,78; oNEW_BEST pulses; oBEST = 357.
REQ-032 Load 500 after 357 -> last result displays 500; oNEW_BEST stays 0; with iSEL_BEST=1 the display shows 357.
REQ-033 Load 12000 -> clamped; display shows 9,9,9,9 (all 10); oBEST unchanged at 9999 after reset, no pulse.
REQ-034 Load 0 -> display shows 7F,7F,7F,40; oBEST = 0; a second iLOAD at N+3 is ignored and oBUSY stays high through N+15.
REQ-035 Load 250, then iCLR_BEST in the COMMIT cycle of a following load of 800 -> oBEST = 800 with a pulse.
REQ-036 Assert iRST_N=0 at N+7 of a conversion -> no update; last display shows "0"; oBEST = 9999.
